// File: rtl/periph_bus_fabric.sv
// Memory-mapped bus fabric: decodes the core's data-port request onto one of
// NUM_SLV slaves through a registered IDLE/ACCESS/RESP handshake with timeout.
module periph_bus_fabric #(
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE =
    {32'h7002_0000, 32'h7001_0000, 32'h7000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK =
    {32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_E000},
  parameter int unsigned DEFAULT_SLV = 0,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         m_addr,
  input  logic                  m_re,
  input  logic                  m_we,
  input  logic [DW/8-1:0]       m_be,
  input  logic [DW-1:0]         m_wdata,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_cs_n,
  output logic                  s_re,
  output logic                  s_we,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_be,
  input  logic [NUM_SLV*DW-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_ready,
  output logic [AW-1:0]         err_addr,
  output logic [7:0]            err_count
);

  localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   sel_q, dec_sel;
  logic            dec_hit;
  logic            re_q, we_q;
  logic [CW-1:0]   wait_cnt;
  logic [DW-1:0]   sel_rdata;
  logic            sel_ready;
  logic            req, dir_re, dir_we;
  logic            resp_d, err_d;

  assign req = m_re | m_we;

  // Direction that will be in force in the next cycle: fresh from the master
  // when leaving IDLE, otherwise the latched copy.
  assign dir_re = (state == IDLE) ? m_re : re_q;
  assign dir_we = (state == IDLE) ? m_we : we_q;

  // Scan high-to-low so the lowest matching index is the last assignment.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = NUM_SLV; i > 0; i--) begin
      if ((m_addr & SLV_MASK[(i-1)*AW +: AW]) == SLV_BASE[(i-1)*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i - 1);
      end
    end
    if (!dec_hit && (DEFAULT_SLV < NUM_SLV)) begin
      dec_hit = 1'b1;
      dec_sel = SW'(DEFAULT_SLV);
    end
  end

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rdata = s_rdata[i*DW +: DW];
        sel_ready = s_ready[i];
      end
    end
  end

  always_comb begin
    s_cs_n = '1;
    if (state == ACCESS) begin
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
        if (sel_q == SW'(i)) s_cs_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!dec_hit || (m_re && m_we)) begin
            state_d = RESP;
            resp_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (sel_ready) begin
          state_d = RESP;
          resp_d  = 1'b1;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          state_d = RESP;
          resp_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
      s_re      <= 1'b0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
      m_rdata   <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state   <= state_d;
      m_ready <= resp_d;
      m_err   <= err_d;
      s_re    <= (state_d == ACCESS) && dir_re;
      s_we    <= (state_d == ACCESS) && dir_we;

      if (state == IDLE && req) begin
        sel_q   <= dec_sel;
        re_q    <= m_re;
        we_q    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_be    <= m_be;
      end

      if (state == ACCESS && state_d == ACCESS) wait_cnt <= CW'(wait_cnt + 1'b1);
      else                                      wait_cnt <= '0;

      if (resp_d) begin
        if (err_d && dir_re)                       m_rdata <= ERR_DATA;
        else if (!err_d && state == ACCESS && re_q) m_rdata <= sel_rdata;
      end

      if (err_d) begin
        err_addr <= (state == IDLE) ? m_addr : s_addr;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Directed bench for periph_bus_fabric: vector table plus hand-written
// back-to-back, reset-abort, no-default-slave and saturation sequences.
module tb_periph_bus_fabric;

  logic         clk;
  logic         reset;
  logic [31:0]  m_addr;
  logic         m_re, m_we, m_re_b;
  logic [3:0]   m_be;
  logic [31:0]  m_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  logic [31:0] m_rdata,   m_rdata_b;
  logic        m_ready,   m_ready_b;
  logic        m_err,     m_err_b;
  logic [3:0]  s_cs_n,    s_cs_n_b;
  logic        s_re,      s_re_b;
  logic        s_we,      s_we_b;
  logic [31:0] s_addr,    s_addr_b;
  logic [31:0] s_wdata,   s_wdata_b;
  logic [3:0]  s_be,      s_be_b;
  logic [31:0] err_addr,  err_addr_b;
  logic [7:0]  err_count, err_count_b;

  int total = 0;
  int bad   = 0;

  periph_bus_fabric #(.NUM_SLV(4), .AW(32), .DW(32), .DEFAULT_SLV(0), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
    .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .m_err(m_err), .s_cs_n(s_cs_n), .s_re(s_re), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_rdata(s_rdata), .s_ready(s_ready),
    .err_addr(err_addr), .err_count(err_count)
  );

  periph_bus_fabric #(.NUM_SLV(4), .AW(32), .DW(32), .DEFAULT_SLV(4), .TIMEOUT(15)) dut_nd (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_re(m_re_b), .m_we(1'b0),
    .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata_b), .m_ready(m_ready_b),
    .m_err(m_err_b), .s_cs_n(s_cs_n_b), .s_re(s_re_b), .s_we(s_we_b), .s_addr(s_addr_b),
    .s_wdata(s_wdata_b), .s_be(s_be_b), .s_rdata(s_rdata), .s_ready(s_ready),
    .err_addr(err_addr_b), .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          slv;
    int          delay;     // ACCESS cycles with ready low before ready; 255 = never
    logic [31:0] sdata;
    logic [3:0]  exp_cs;
    int          exp_acc;
    int          exp_lat;   // cycle of m_ready counted from the sampling edge
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  acc;
    int  lat;
    bit  done;
    bit  st_ok;
    acc = 0; lat = 0; done = 0; st_ok = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      s_rdata[i*32 +: 32] = (i == v.slv) ? v.sdata : (32'hBAD0_0000 | 32'(i));
    s_ready = 4'hF;
    s_ready[v.slv] = 1'b0;
    m_addr = v.addr; m_re = v.re; m_we = v.we; m_be = v.be; m_wdata = v.wdata;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (s_cs_n != 4'hF) begin
        acc++;
        if (s_cs_n != v.exp_cs || s_re != v.re || s_we != v.we || s_addr != v.addr ||
            s_wdata != v.wdata || s_be != v.be) st_ok = 0;
        s_ready[v.slv] = (acc > v.delay);
      end else begin
        s_ready[v.slv] = 1'b0;
      end
      if (m_ready) begin
        done = 1;
        lat  = c;
        chk($sformatf("v%0d_err", idx), 32'(m_err), 32'(v.exp_err));
        if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), m_rdata, v.exp_rd);
        m_re = 1'b0; m_we = 1'b0;
      end else if (m_err) begin
        st_ok = 0;
      end
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_acc", idx), 32'(acc), 32'(v.exp_acc));
    chk($sformatf("v%0d_slave_side", idx), 32'(st_ok), 32'd1);
  endtask

  initial begin
    int acc;
    int n;
    int c1;
    int c2;
    bit cs_bad;

    //         addr          re    we    be     wdata         slv dly  sdata         cs       acc lat err   chk   exp_rd
    vecs[0] = '{32'h7000_0010, 1'b1, 1'b0, 4'hF, 32'h0,         1, 0,   32'h1234_5678, 4'b1101, 1,  2,  1'b0, 1'b1, 32'h1234_5678};
    vecs[1] = '{32'h7001_0008, 1'b0, 1'b1, 4'h3, 32'hA5A5_A5A5, 2, 3,   32'hFFFF_0000, 4'b1011, 4,  5,  1'b0, 1'b1, 32'h1234_5678};
    vecs[2] = '{32'h9000_0000, 1'b1, 1'b0, 4'hF, 32'h0,         0, 0,   32'hCAFE_0001, 4'b1110, 1,  2,  1'b0, 1'b1, 32'hCAFE_0001};
    vecs[3] = '{32'h0000_1FFC, 1'b1, 1'b0, 4'hF, 32'h0,         0, 1,   32'h0BAD_F00D, 4'b1110, 2,  3,  1'b0, 1'b1, 32'h0BAD_F00D};
    vecs[4] = '{32'h7002_0FF0, 1'b1, 1'b0, 4'hF, 32'h0,         3, 255, 32'h5555_AAAA, 4'b0111, 16, 17, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{32'h7002_0FF0, 1'b1, 1'b0, 4'hF, 32'h0,         3, 15,  32'h5555_AAAA, 4'b0111, 16, 17, 1'b0, 1'b1, 32'h5555_AAAA};
    vecs[6] = '{32'h7001_0010, 1'b1, 1'b0, 4'hF, 32'h0,         0, 0,   32'h0000_0777, 4'b1110, 1,  2,  1'b0, 1'b1, 32'h0000_0777};
    vecs[7] = '{32'h7000_0800, 1'b0, 1'b1, 4'hF, 32'h0F0F_0F0F, 1, 255, 32'h0,         4'b1101, 16, 17, 1'b1, 1'b1, 32'h0000_0777};
    vecs[8] = '{32'h7000_0000, 1'b1, 1'b1, 4'hF, 32'h0,         1, 0,   32'h0,         4'b1111, 0,  1,  1'b1, 1'b0, 32'h0};

    reset = 1'b0; m_addr = '0; m_re = 1'b0; m_we = 1'b0; m_re_b = 1'b0;
    m_be = '0; m_wdata = '0; s_rdata = '0; s_ready = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",      32'(s_cs_n), 32'hF);
    chk("rst_s_re_we",   {30'd0, s_re, s_we}, 32'd0);
    chk("rst_m_ready",   {30'd0, m_ready, m_err}, 32'd0);
    chk("rst_m_rdata",   m_rdata, 32'd0);
    chk("rst_err_addr",  err_addr, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_s_addr",    s_addr, 32'd0);
    chk("rst_s_wdata",   s_wdata, 32'd0);
    chk("rst_s_be",      32'(s_be), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("log_err_count", 32'(err_count), 32'd3);
    chk("log_err_addr",  err_addr, 32'h7000_0000);

    // back-to-back reads, request held across the IDLE cycle
    @(negedge clk);
    s_ready = 4'hF;
    s_rdata[31:0]  = 32'h1111_0000;
    s_rdata[63:32] = 32'h2222_0001;
    m_addr = 32'h0000_0100; m_re = 1'b1;
    n = 0; c1 = 0; c2 = 0;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(negedge clk);
      if (m_ready) begin
        n++;
        if (n == 1) begin
          c1 = c;
          chk("b2b_rd0", m_rdata, 32'h1111_0000);
          m_addr = 32'h7000_0020;
        end else begin
          c2 = c;
          chk("b2b_rd1", m_rdata, 32'h2222_0001);
          chk("b2b_err1", 32'(m_err), 32'd0);
          m_re = 1'b0;
        end
      end
    end
    chk("b2b_first_lat", 32'(c1), 32'd2);
    chk("b2b_spacing",   32'(c2 - c1), 32'd3);

    // reset during ACCESS aborts the transfer
    @(negedge clk);
    s_ready = 4'h0;
    m_addr = 32'h7000_0010; m_re = 1'b1;
    acc = 0;
    for (int c = 1; c <= 6 && acc < 3; c++) begin
      @(negedge clk);
      if (s_cs_n != 4'hF) acc++;
    end
    chk("rstmid_acc", 32'(acc), 32'd3);
    reset = 1'b0;
    #1;
    chk("rstmid_cs_n",      32'(s_cs_n), 32'hF);
    chk("rstmid_m_ready",   32'(m_ready), 32'd0);
    chk("rstmid_s_re",      32'(s_re), 32'd0);
    chk("rstmid_err_count", 32'(err_count), 32'd0);
    m_re = 1'b0;
    @(negedge clk);
    chk("rstmid_no_ready", 32'(m_ready), 32'd0);
    reset = 1'b1;
    run_vec(vecs[0], 100);

    // no default slave: decode miss is an error
    @(negedge clk);
    m_addr = 32'h9000_0000; m_re_b = 1'b1;
    cs_bad = 0; c1 = 0;
    for (int c = 1; c <= 10 && c1 == 0; c++) begin
      @(negedge clk);
      if (s_cs_n_b != 4'hF) cs_bad = 1;
      if (m_ready_b) begin
        c1 = c;
        chk("nd_err",       32'(m_err_b), 32'd1);
        chk("nd_rdata",     m_rdata_b, 32'hDEAD_BEEF);
        chk("nd_err_addr",  err_addr_b, 32'h9000_0000);
        chk("nd_err_count", 32'(err_count_b), 32'd1);
        m_re_b = 1'b0;
      end
    end
    chk("nd_lat",   32'(c1), 32'd1);
    chk("nd_no_cs", 32'(cs_bad), 32'd0);

    // saturation: 270 further back-to-back errors
    @(negedge clk);
    m_re_b = 1'b1;
    n = 0;
    for (int c = 1; c <= 700 && n < 270; c++) begin
      @(negedge clk);
      if (m_ready_b) begin
        n++;
        if (n == 253) chk("sat_254", 32'(err_count_b), 32'd254);
        if (n == 254) chk("sat_255", 32'(err_count_b), 32'd255);
        if (n == 270) m_re_b = 1'b0;
      end
    end
    m_re_b = 1'b0;
    chk("sat_pulses", 32'(n), 32'd270);
    chk("sat_final",  32'(err_count_b), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/periph_bus_fabric.md
# periph_bus_fabric

Parametrised memory-mapped bus fabric between the ARM core's data port and NUM_SLV peripheral/memory slaves. It replaces a fixed address decoder plus priority read mux. Each access passes through a registered handshake FSM with per-slave wait states, a configurable default slave, decode-miss and timeout error reporting, and a sticky error log.

## Interface
Parameters:
- NUM_SLV, 4: number of slave channels (1..8)
- AW, 32: address width
- DW, 32: data width; byte-enable width is DW/8
- SLV_BASE, {0x0000_0000, 0x7000_0000, 0x7001_0000, 0x7002_0000}: flattened NUM_SLV*AW bits; slave i base at [i*AW +: AW]
- SLV_MASK, {0xFFFF_E000, 0xFFFF_F000, 0xFFFF_FFF0, 0xFFFF_F000}: flattened like SLV_BASE
- DEFAULT_SLV, 0: slave selected on decode miss; value NUM_SLV means "none", so a miss is an error
- TIMEOUT, 15: wait-state cycles tolerated before a bus error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_addr  in  AW  master address
- m_re / m_we  in  1 each  master read / write request, active high
- m_be  in  DW/8  byte enables
- m_wdata  in  DW  write data
- m_rdata  out  DW  registered read data
- m_ready  out  1  one-cycle completion strobe
- m_err  out  1  error flag, valid with m_ready
- s_cs_n  out  NUM_SLV  per-slave chip select, active low
- s_re / s_we  out  1 each  latched direction, asserted only in ACCESS
- s_addr / s_wdata / s_be  out  AW / DW / DW/8  latched request
- s_rdata  in  NUM_SLV*DW  flattened slave read data
- s_ready  in  NUM_SLV  per-slave completion
- err_addr  out  AW  address of the most recent errored access
- err_count  out  8  errored-access count, saturates at 255

## Operation
- Decode: slave i hits when (m_addr & MASK_i) == BASE_i. On overlap the lowest index wins. On a miss the fabric selects DEFAULT_SLV; if DEFAULT_SLV==NUM_SLV the miss is an error.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - The fabric samples the request (m_re|m_we) and latches addr, wdata, be, direction and the selected index.
  - Valid hit goes to ACCESS.
  - Decode error, or m_re&m_we both high, goes straight to RESP with err=1; no chip select is asserted.
- ACCESS:
  - s_cs_n[sel]=0 and all other bits are 1; s_re/s_we carry the latched direction.
  - When s_ready[sel]=1, reads load s_rdata[sel] into m_rdata and writes leave m_rdata unchanged. Next state is RESP with err=0.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, next state is RESP with err=1.
  - If s_ready and timeout occur in the same cycle, ready wins.
  - s_ready from unselected slaves is ignored.
- RESP:
  - m_ready=1 and m_err=err for exactly one cycle; next state is IDLE.
  - On a read error, m_rdata=0xDEAD_BEEF.
  - On any error, err_addr takes the latched address and err_count increments (saturating).
- The master holds its request stable until it sees m_ready and must drop it in the IDLE cycle that follows. A request still high in IDLE starts a new transaction, so back-to-back accesses are legal.

## Timing
- Reset (asynchronous, reset=0):
  - state=IDLE, s_cs_n all 1, s_re=s_we=0, m_ready=0, m_err=0.
  - m_rdata=0, err_addr=0, err_count=0, wait counter=0.
  - s_addr, s_wdata and s_be are 0.
  - A reset mid-transaction aborts it; no m_ready is issued.
- Zero-wait access:
  - Request seen in IDLE at edge 0.
  - ACCESS during cycle 1, with s_ready sampled at edge 1.
  - m_ready high during cycle 2, with m_rdata valid in the same cycle.
  - Minimum cost is 3 cycles per transaction.
- Wait states: each low s_ready cycle adds one cycle. The maximum is TIMEOUT waits; the error is flagged after TIMEOUT+1 ACCESS cycles without ready.
- Decode error response: m_ready is asserted in the cycle after IDLE, i.e. 2 cycles per transaction.
- Outputs are registered except s_cs_n, which is decoded from the state and latched index.

## Test plan
- Read slave 1 at 0x7000_0010, s_ready=1 immediately, s_rdata[1]=0x1234_5678 -> s_cs_n=4'b1101 for one cycle; m_ready in cycle 2 with m_rdata=0x1234_5678 and m_err=0.
- Write 0xA5A5_A5A5 to slave 2 with m_be=4'b0011, s_ready delayed 3 cycles -> s_we, s_be and s_wdata stable for 4 ACCESS cycles; m_ready 5 cycles after the request; m_rdata unchanged.
- Read 0x9000_0000 with DEFAULT_SLV=0 -> slave 0 selected and normal completion. Same access with DEFAULT_SLV=NUM_SLV -> no chip select, m_ready and m_err high in cycle 1, m_rdata=0xDEAD_BEEF, err_addr=0x9000_0000, err_count=1.
- Slave 3 never asserts ready with TIMEOUT=15 -> m_err with m_ready after 16 ACCESS cycles. Second run asserts ready on the 16th ACCESS cycle -> m_err=0.
- Back-to-back reads to slaves 0 and 1 with the request held continuously -> two m_ready pulses 3 cycles apart with correct data each; m_re&m_we together -> error response.
- Assert reset during ACCESS -> s_cs_n all 1 and m_ready=0 immediately; after release the next read completes normally. 256 forced errors -> err_count stays at 255.
